// File: rtl/vx_tcu_pkg.sv
// Shared TCU definitions: format IDs, lane count and the DRL sequencer state type.
package vx_tcu_pkg;

    localparam int TCU_MAX_INPUTS = 16;

    localparam logic [2:0] TCU_FP32_ID = 3'd0;
    localparam logic [2:0] TCU_FP16_ID = 3'd1;
    localparam logic [2:0] TCU_BF16_ID = 3'd2;
    localparam logic [2:0] TCU_FP8_ID  = 3'd3;
    localparam logic [2:0] TCU_BF8_ID  = 3'd4;
    localparam logic [2:0] TCU_TF32_ID = 3'd5;

    typedef enum logic [2:0] {
        TCU_SEQ_IDLE  = 3'd0,
        TCU_SEQ_ISSUE = 3'd1,
        TCU_SEQ_WAIT  = 3'd2,
        TCU_SEQ_DRAIN = 3'd3,
        TCU_SEQ_DONE  = 3'd4
    } tcu_seq_state_t;

    // Formats the exponent/FEDP datapath can accumulate; FP32 and unassigned IDs are rejected.
    function automatic logic tcu_fmt_legal(input logic [2:0] fmt);
        logic ok;
        case (fmt)
            TCU_TF32_ID, TCU_FP16_ID, TCU_BF16_ID,
            TCU_FP8_ID,  TCU_BF8_ID:  ok = 1'b1;
            default:                  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/vx_tcu_drl_seq.sv
// TCU dot-product request sequencer: splits a request into K beats spaced by the
// accumulate latency so each beat sees the previous partial sum.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a request, req_ready high
// ISSUE | beat kidx presented on dp_*, waiting for dp_ready
// WAIT  | gap counter running between beats (accumulator RAW hazard)
// DRAIN | gap counter running after the last beat
// DONE  | done_valid/done_err presented, waiting for done_ready
module vx_tcu_drl_seq
    import vx_tcu_pkg::*;
#(
    parameter  int LAT   = 4,
    parameter  int MAX_K = 16,
    localparam int KW    = $clog2(MAX_K + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                req_fmt,
    input  logic [KW-1:0]             req_ksteps,
    input  logic [TCU_MAX_INPUTS-1:0] req_tail_mask,

    output logic                      dp_valid,
    input  logic                      dp_ready,
    output logic [2:0]                dp_fmt,
    output logic [TCU_MAX_INPUTS-1:0] dp_vld_mask,
    output logic [KW-1:0]             dp_kidx,
    output logic                      dp_c_sel,
    output logic                      dp_last,

    output logic                      done_valid,
    input  logic                      done_ready,
    output logic                      done_err
);

    localparam int GW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(LAT - 1);

    typedef struct packed {
        logic [2:0]                fmt;
        logic [TCU_MAX_INPUTS-1:0] mask;
        logic [KW-1:0]             kidx;
        logic                      c_sel;
        logic                      last;
    } beat_t;

    tcu_seq_state_t            state;
    logic [2:0]                fmt_q;
    logic [KW-1:0]             ksteps_q;
    logic [TCU_MAX_INPUTS-1:0] tail_q;
    logic [KW-1:0]             kidx;
    logic [KW-1:0]             kidx_inc;
    logic [GW-1:0]             gap;
    beat_t                     beat_q;

    // Beat fields for a given K index: first beat takes external C, later beats feed back.
    function automatic beat_t make_beat(
        input logic [2:0]                fmt,
        input logic [KW-1:0]             idx,
        input logic [KW-1:0]             ksteps,
        input logic [TCU_MAX_INPUTS-1:0] tail
    );
        beat_t b;
        b.fmt   = fmt;
        b.kidx  = idx;
        b.c_sel = (idx != '0);
        b.last  = ((idx + KW'(1)) == ksteps);
        b.mask  = b.last ? tail : '1;
        return b;
    endfunction

    assign kidx_inc = kidx + KW'(1);

    // Ready only while idle and out of reset, so it is low throughout reset and
    // high in the very first cycle after release.
    assign req_ready = (state == TCU_SEQ_IDLE) && reset_n;

    assign dp_fmt      = beat_q.fmt;
    assign dp_vld_mask = beat_q.mask;
    assign dp_kidx     = beat_q.kidx;
    assign dp_c_sel    = beat_q.c_sel;
    assign dp_last     = beat_q.last;

    // Sequencer FSM with beat counter, gap counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= TCU_SEQ_IDLE;
            fmt_q      <= '0;
            ksteps_q   <= '0;
            tail_q     <= '0;
            kidx       <= '0;
            gap        <= '0;
            beat_q     <= '0;
            dp_valid   <= 1'b0;
            done_valid <= 1'b0;
            done_err   <= 1'b0;
        end else begin
            case (state)
                TCU_SEQ_IDLE: begin
                    if (req_valid) begin
                        fmt_q    <= req_fmt;
                        ksteps_q <= req_ksteps;
                        tail_q   <= req_tail_mask;
                        kidx     <= '0;
                        if (!tcu_fmt_legal(req_fmt)) begin
                            state      <= TCU_SEQ_DONE;
                            done_valid <= 1'b1;
                            done_err   <= 1'b1;
                        end else if (req_ksteps == '0) begin
                            state      <= TCU_SEQ_DONE;
                            done_valid <= 1'b1;
                            done_err   <= 1'b0;
                        end else begin
                            state    <= TCU_SEQ_ISSUE;
                            dp_valid <= 1'b1;
                            beat_q   <= make_beat(req_fmt, '0, req_ksteps, req_tail_mask);
                        end
                    end
                end

                TCU_SEQ_ISSUE: begin
                    // A stalled beat simply stays registered; nothing advances.
                    if (dp_ready) begin
                        if (beat_q.last) begin
                            dp_valid <= 1'b0;
                            beat_q   <= '0;
                            if (LAT == 1) begin
                                state      <= TCU_SEQ_DONE;
                                done_valid <= 1'b1;
                                done_err   <= 1'b0;
                            end else begin
                                state <= TCU_SEQ_DRAIN;
                                gap   <= GAP_LOAD;
                            end
                        end else begin
                            kidx <= kidx_inc;
                            if (LAT == 1) begin
                                beat_q <= make_beat(fmt_q, kidx_inc, ksteps_q, tail_q);
                            end else begin
                                state    <= TCU_SEQ_WAIT;
                                gap      <= GAP_LOAD;
                                dp_valid <= 1'b0;
                                beat_q   <= '0;
                            end
                        end
                    end
                end

                TCU_SEQ_WAIT: begin
                    gap <= gap - GW'(1);
                    if (gap <= GW'(1)) begin
                        state    <= TCU_SEQ_ISSUE;
                        dp_valid <= 1'b1;
                        beat_q   <= make_beat(fmt_q, kidx, ksteps_q, tail_q);
                    end
                end

                TCU_SEQ_DRAIN: begin
                    gap <= gap - GW'(1);
                    if (gap <= GW'(1)) begin
                        state      <= TCU_SEQ_DONE;
                        done_valid <= 1'b1;
                        done_err   <= 1'b0;
                    end
                end

                TCU_SEQ_DONE: begin
                    if (done_ready) begin
                        state      <= TCU_SEQ_IDLE;
                        done_valid <= 1'b0;
                        done_err   <= 1'b0;
                    end
                end

                default: begin
                    state      <= TCU_SEQ_IDLE;
                    dp_valid   <= 1'b0;
                    beat_q     <= '0;
                    done_valid <= 1'b0;
                    done_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vx_tcu_drl_seq.sv
// Directed bench for the TCU DRL sequencer: one LAT=4 and one LAT=1 instance.
module tb_vx_tcu_drl_seq;
    import vx_tcu_pkg::*;

    localparam int KW = 5;
    localparam int M  = TCU_MAX_INPUTS;
    localparam int BW = 3 + M + KW + 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]    req_fmt       = '0;
    logic [KW-1:0] req_ksteps    = '0;
    logic [M-1:0]  req_tail_mask = '0;
    logic          req_valid4    = 1'b0;
    logic          req_valid1    = 1'b0;
    logic          dp_ready      = 1'b1;
    logic          done_ready    = 1'b0;
    logic          tb_sel        = 1'b0;

    logic          req_ready4, dp_valid4, dp_c_sel4, dp_last4, done_valid4, done_err4;
    logic [2:0]    dp_fmt4;
    logic [M-1:0]  dp_vld_mask4;
    logic [KW-1:0] dp_kidx4;
    logic          req_ready1, dp_valid1, dp_c_sel1, dp_last1, done_valid1, done_err1;
    logic [2:0]    dp_fmt1;
    logic [M-1:0]  dp_vld_mask1;
    logic [KW-1:0] dp_kidx1;

    vx_tcu_drl_seq #(.LAT(4), .MAX_K(16)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_fmt(req_fmt),
        .req_ksteps(req_ksteps), .req_tail_mask(req_tail_mask),
        .dp_valid(dp_valid4), .dp_ready(dp_ready), .dp_fmt(dp_fmt4),
        .dp_vld_mask(dp_vld_mask4), .dp_kidx(dp_kidx4), .dp_c_sel(dp_c_sel4),
        .dp_last(dp_last4), .done_valid(done_valid4), .done_ready(done_ready),
        .done_err(done_err4)
    );

    vx_tcu_drl_seq #(.LAT(1), .MAX_K(16)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_fmt(req_fmt),
        .req_ksteps(req_ksteps), .req_tail_mask(req_tail_mask),
        .dp_valid(dp_valid1), .dp_ready(dp_ready), .dp_fmt(dp_fmt1),
        .dp_vld_mask(dp_vld_mask1), .dp_kidx(dp_kidx1), .dp_c_sel(dp_c_sel1),
        .dp_last(dp_last1), .done_valid(done_valid1), .done_ready(done_ready),
        .done_err(done_err1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_dv();
        return tb_sel ? dp_valid1 : dp_valid4;
    endfunction
    function automatic logic cur_req_ready();
        return tb_sel ? req_ready1 : req_ready4;
    endfunction
    function automatic logic cur_done_valid();
        return tb_sel ? done_valid1 : done_valid4;
    endfunction
    function automatic logic cur_done_err();
        return tb_sel ? done_err1 : done_err4;
    endfunction
    function automatic logic [BW-1:0] cur_beat();
        return tb_sel ? {dp_fmt1, dp_vld_mask1, dp_kidx1, dp_c_sel1, dp_last1}
                      : {dp_fmt4, dp_vld_mask4, dp_kidx4, dp_c_sel4, dp_last4};
    endfunction
    function automatic logic [BW-1:0] exp_beat(input logic [2:0] f, input logic [M-1:0] mask,
                                               input int k, input logic csel, input logic last);
        return {f, mask, KW'(k), csel, last};
    endfunction

    int            b_edge [8];
    logic [BW-1:0] b_fld  [8];
    int            n_beats, done_at, stall_cnt, hold_bad, zero_bad;
    logic          done_err_seen;

    // Presents one request on the selected DUT; acc is the accept edge number.
    task automatic send(input logic sel, input logic [2:0] f, input int ks,
                        input logic [M-1:0] t, output int acc);
        @(negedge clk);
        tb_sel = sel;
        check("req_ready_at_send", cur_req_ready(), 1'b1);
        req_fmt       = f;
        req_ksteps    = KW'(ks);
        req_tail_mask = t;
        if (sel) req_valid1 = 1'b1;
        else     req_valid4 = 1'b1;
        acc = cyc + 1;
        @(posedge clk);
        #1;
        req_valid1 = 1'b0;
        req_valid4 = 1'b0;
    endtask

    // Records fired beats (edge numbers and fields) until done_valid or the budget runs out.
    task automatic collect(input int stall0, input int budget);
        int            stall_left;
        logic          stalled_prev;
        logic [BW-1:0] prev;
        logic          got;
        stall_left = stall0;
        stalled_prev = 1'b0;
        prev = '0;
        got = 1'b0;
        n_beats = 0; done_at = -1; stall_cnt = 0; hold_bad = 0; zero_bad = 0;
        done_err_seen = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (cur_dv() && stall_left > 0) begin
                dp_ready = 1'b0;
                stall_left--;
                stall_cnt++;
            end else begin
                dp_ready = 1'b1;
            end
            if (stalled_prev && (!cur_dv() || cur_beat() !== prev)) hold_bad++;
            if (!cur_dv() && cur_beat() !== '0) zero_bad++;
            if (cur_dv() && dp_ready) begin
                if (n_beats < 8) begin
                    b_edge[n_beats] = cyc + 1;
                    b_fld[n_beats]  = cur_beat();
                end
                n_beats++;
            end
            stalled_prev = cur_dv() && !dp_ready;
            prev = cur_beat();
            if (cur_done_valid()) begin
                got = 1'b1;
                done_at = cyc + 1;
                done_err_seen = cur_done_err();
            end
        end
        dp_ready = 1'b1;
    endtask

    task automatic finish_done();
        done_ready = 1'b1;
        @(negedge clk);
        check("done_valid_cleared", cur_done_valid(), 1'b0);
        check("req_ready_after_done", cur_req_ready(), 1'b1);
        done_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready4", req_ready4, 1'b0);
        check("rst_req_ready1", req_ready1, 1'b0);
        check("rst_dp_valid4", dp_valid4, 1'b0);
        check("rst_done_valid4", done_valid4, 1'b0);
        check("rst_beat4", {dp_fmt4, dp_vld_mask4, dp_kidx4, dp_c_sel4, dp_last4}, '0);
        reset_n = 1'b1;
        #1;
        check("rel_req_ready4", req_ready4, 1'b1);

        // LAT=4, FP16, 3 steps, no stall
        send(1'b0, TCU_FP16_ID, 3, 16'h00FF, a);
        collect(0, 40);
        check("t1_nbeats", n_beats, 3);
        check("t1_edge0", b_edge[0], a + 1);
        check("t1_edge1", b_edge[1], a + 5);
        check("t1_edge2", b_edge[2], a + 9);
        check("t1_beat0", b_fld[0], exp_beat(TCU_FP16_ID, 16'hFFFF, 0, 1'b0, 1'b0));
        check("t1_beat1", b_fld[1], exp_beat(TCU_FP16_ID, 16'hFFFF, 1, 1'b1, 1'b0));
        check("t1_beat2", b_fld[2], exp_beat(TCU_FP16_ID, 16'h00FF, 2, 1'b1, 1'b1));
        check("t1_done_at", done_at, a + 13);
        check("t1_done_err", done_err_seen, 1'b0);
        check("t1_idle_zero", zero_bad, 0);
        finish_done();

        // Illegal format
        send(1'b0, 3'd7, 3, 16'h1234, a);
        collect(0, 10);
        check("t2_nbeats", n_beats, 0);
        check("t2_done_at", done_at, a + 1);
        check("t2_done_err", done_err_seen, 1'b1);
        finish_done();

        // Zero K-steps with a legal format
        send(1'b0, TCU_BF8_ID, 0, 16'h1234, a);
        collect(0, 10);
        check("t3_nbeats", n_beats, 0);
        check("t3_done_at", done_at, a + 1);
        check("t3_done_err", done_err_seen, 1'b0);
        finish_done();

        // Stall on beat 0
        send(1'b0, TCU_TF32_ID, 2, 16'h3C3C, a);
        collect(3, 40);
        check("t4_nbeats", n_beats, 2);
        check("t4_stalls", stall_cnt, 3);
        check("t4_hold", hold_bad, 0);
        check("t4_idle_zero", zero_bad, 0);
        check("t4_edge0", b_edge[0], a + 4);
        check("t4_gap", b_edge[1] - b_edge[0], 4);
        check("t4_beat0", b_fld[0], exp_beat(TCU_TF32_ID, 16'hFFFF, 0, 1'b0, 1'b0));
        check("t4_beat1", b_fld[1], exp_beat(TCU_TF32_ID, 16'h3C3C, 1, 1'b1, 1'b1));
        check("t4_done_at", done_at, a + 12);
        check("t4_done_err", done_err_seen, 1'b0);
        finish_done();

        // Reset during WAIT of a 4-step request
        send(1'b0, TCU_FP16_ID, 4, 16'hAAAA, a);
        @(negedge clk);
        check("t5_beat0_valid", dp_valid4, 1'b1);
        @(negedge clk);
        check("t5_wait_valid", dp_valid4, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        check("t5_rst_req_ready", req_ready4, 1'b0);
        check("t5_rst_dp_valid", dp_valid4, 1'b0);
        check("t5_rst_done", {done_valid4, done_err4}, 2'b00);
        check("t5_rst_beat", {dp_fmt4, dp_vld_mask4, dp_kidx4, dp_c_sel4, dp_last4}, '0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t5_rst_hold", {req_ready4, dp_valid4, done_valid4}, 3'b000);
        end
        reset_n = 1'b1;
        #1;
        check("t5_rel_req_ready", req_ready4, 1'b1);
        send(1'b0, TCU_FP16_ID, 1, 16'h0F0F, a);
        collect(0, 20);
        check("t5_nbeats", n_beats, 1);
        check("t5_edge0", b_edge[0], a + 1);
        check("t5_beat0", b_fld[0], exp_beat(TCU_FP16_ID, 16'h0F0F, 0, 1'b0, 1'b1));
        check("t5_done_at", done_at, a + 5);
        check("t5_done_err", done_err_seen, 1'b0);
        finish_done();

        // LAT=1, FP8, 4 back-to-back steps, done held under backpressure
        send(1'b1, TCU_FP8_ID, 4, 16'hF00F, a);
        collect(0, 20);
        check("t6_nbeats", n_beats, 4);
        for (int k = 0; k < 4; k++) begin
            check("t6_edge", b_edge[k], a + 1 + k);
            check("t6_beat", b_fld[k],
                  exp_beat(TCU_FP8_ID, (k == 3) ? 16'hF00F : 16'hFFFF, k, k != 0, k == 3));
        end
        check("t6_done_at", done_at, a + 5);
        check("t6_done_err", done_err_seen, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t6_done_held", done_valid1, 1'b1);
        end
        finish_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
